dzcpu_useq: RTL and testbench

DZCPU_USEQ -- requirements
Module: dzcpu_useq

---
 rtl/dzcpu_useq_pkg.sv | 34 +++
 rtl/dzcpu_useq_ram.sv | 35 +++
 rtl/dzcpu_useq.sv | 180 ++++++++++++++++++
 tb/tb_dzcpu_useq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg -- shared encodings for the DZCPU micro-sequencer.
//   seq_e   : sequencing field (top SEQ_W bits of every micro-op)
//   state_e : sequencer FSM states
//   field widths and the dispatch-table address helper
package dzcpu_useq_pkg;

  localparam int SEQ_W  = 3;   // SEQ lives in uop[UOP_W-1 -: SEQ_W]
  localparam int MOP_W  = 8;   // opcode byte
  localparam int LUT_AW = 9;   // {cb, opcode}

  typedef enum logic [SEQ_W-1:0] {
    SEQ_NEXT   = 3'd0,
    SEQ_EOF    = 3'd1,
    SEQ_EOF_Z  = 3'd2,
    SEQ_EOF_NZ = 3'd3,
    SEQ_JCB    = 3'd4,
    SEQ_JMP    = 3'd5,
    SEQ_CALL   = 3'd6,
    SEQ_RET    = 3'd7
  } seq_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WAITCB = 2'd3
  } state_e;

  // Dispatch-table index: the CB-prefixed page sits in the upper half.
  function automatic logic [LUT_AW-1:0] lut_addr(input logic cb, input logic [MOP_W-1:0] mop);
    return {cb, mop};
  endfunction

endpackage

// File: rtl/dzcpu_useq_ram.sv
// dzcpu_useq_ram -- one write port, one registered read port.
//   iClock/iReset       : clock; iReset clears only the read register
//   iWe/iWaddr/iWdata   : write port
//   iRe/iRaddr/oRdata   : read port, data one cycle after iRe; held while iRe=0
// Contents power up at zero and survive reset. A read and a write of the
// same address in one cycle returns the old contents.
module dzcpu_useq_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          iWe,
  input  logic [AW-1:0] iWaddr,
  input  logic [DW-1:0] iWdata,
  input  logic          iRe,
  input  logic [AW-1:0] iRaddr,
  output logic [DW-1:0] oRdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] rdata_q;

  always_ff @(posedge iClock) begin
    if (iWe) mem[iWaddr] <= iWdata;
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)   rdata_q <= '0;
    else if (iRe) rdata_q <= mem[iRaddr];
  end

  assign oRdata = rdata_q;

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq -- micro-op sequencer. An opcode byte is dispatched through a
// LUT into a micro-ROM flow; each micro-op costs a FETCH and an EXEC cycle.
//   iMop/iMopValid/oMopAck : opcode byte in, one-cycle ack per accepted byte
//   iFlagZ, iStall         : conditional-end flag, hold current micro-op
//   iRom*, iLut*           : micro-ROM and dispatch-table write ports
//   oUop/oUopValid/oUpc    : current micro-op (valid only in EXEC) and uPC
//   oBusy, oStackErr       : not idle; sticky micro-stack over/underflow
// Build option: DZCPU_USTACK_EN adds a STACK_DEPTH-entry call stack; without
// it CALL acts as JMP, RET as EOF and oStackErr stays 0.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UOP_W       = 16,
  parameter int UPC_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [MOP_W-1:0]  iMop,
  input  logic              iMopValid,
  input  logic              iFlagZ,
  input  logic              iStall,
  input  logic              iRomWe,
  input  logic [UPC_W-1:0]  iRomAddr,
  input  logic [UOP_W-1:0]  iRomData,
  input  logic              iLutWe,
  input  logic [LUT_AW-1:0] iLutAddr,
  input  logic [UPC_W-1:0]  iLutData,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  output logic [UPC_W-1:0]  oUpc,
  output logic              oBusy,
  output logic              oMopAck,
  output logic              oStackErr
);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("STACK_DEPTH must be at least 1");
  end

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d, upc_inc, tgt;
  logic             from_lut_q, from_lut_d;  // FETCH address comes from the LUT read
  logic             valid_q, valid_d, busy_q, busy_d, ack_q, ack_d, err_q, err_d;
  logic [UOP_W-1:0] rom_rdata;
  logic [UPC_W-1:0] lut_rdata, rom_raddr;
  logic             lut_re, rom_re;
  seq_e             seq;

  assign lut_re    = iMopValid && (state_q == ST_IDLE || state_q == ST_WAITCB);
  assign rom_re    = (state_q == ST_FETCH);
  assign rom_raddr = from_lut_q ? lut_rdata : upc_q;
  assign seq       = seq_e'(rom_rdata[UOP_W-1 -: SEQ_W]);
  assign tgt       = rom_rdata[UPC_W-1:0];
  assign upc_inc   = upc_q + 1'b1;   // wraps at 2**UPC_W

  dzcpu_useq_ram #(.AW(LUT_AW), .DW(UPC_W)) u_lut (
    .iClock(iClock), .iReset(iReset),
    .iWe(iLutWe), .iWaddr(iLutAddr), .iWdata(iLutData),
    .iRe(lut_re), .iRaddr(lut_addr(state_q == ST_WAITCB, iMop)), .oRdata(lut_rdata)
  );

  // ROM is only read in FETCH, so its read register doubles as the held oUop.
  dzcpu_useq_ram #(.AW(UPC_W), .DW(UOP_W)) u_rom (
    .iClock(iClock), .iReset(iReset),
    .iWe(iRomWe), .iWaddr(iRomAddr), .iWdata(iRomData),
    .iRe(rom_re), .iRaddr(rom_raddr), .oRdata(rom_rdata)
  );

`ifdef DZCPU_USTACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [UPC_W-1:0] stk_q [STACK_DEPTH];
  logic             push;

  always_ff @(posedge iClock) begin
    if (push) stk_q[IDX_W'(sp_q)] <= upc_inc;
  end
`endif

  always_comb begin
    state_d    = state_q;
    upc_d      = upc_q;
    from_lut_d = from_lut_q;
    ack_d      = 1'b0;
    err_d      = err_q;
`ifdef DZCPU_USTACK_EN
    sp_d = sp_q;
    push = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_WAITCB: begin
        if (iMopValid) begin
          ack_d      = 1'b1;
          from_lut_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        upc_d      = rom_raddr;
        from_lut_d = 1'b0;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        if (!iStall) begin
          state_d = ST_FETCH;
          case (seq)
            SEQ_NEXT:   upc_d = upc_inc;
            SEQ_EOF:    state_d = ST_IDLE;
            SEQ_EOF_Z:  if (iFlagZ) state_d = ST_IDLE; else upc_d = upc_inc;
            SEQ_EOF_NZ: if (!iFlagZ) state_d = ST_IDLE; else upc_d = upc_inc;
            SEQ_JCB:    state_d = ST_WAITCB;
            SEQ_JMP:    upc_d = tgt;
`ifdef DZCPU_USTACK_EN
            SEQ_CALL: begin
              upc_d = tgt;  // overflow drops the return address but still jumps
              if (sp_q == SP_W'(STACK_DEPTH)) err_d = 1'b1;
              else begin
                push = 1'b1;
                sp_d = sp_q + 1'b1;
              end
            end
            SEQ_RET: begin
              if (sp_q == '0) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                upc_d = stk_q[IDX_W'(sp_q - 1'b1)];
                sp_d  = sp_q - 1'b1;
              end
            end
`else
            SEQ_CALL: upc_d = tgt;
            SEQ_RET:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_EXEC);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q    <= ST_IDLE;
      upc_q      <= '0;
      from_lut_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef DZCPU_USTACK_EN
      sp_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      upc_q      <= upc_d;
      from_lut_q <= from_lut_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
`ifdef DZCPU_USTACK_EN
      sp_q       <= sp_d;
`endif
    end
  end

  assign oUop      = rom_rdata;
  assign oUopValid = valid_q;
  assign oUpc      = upc_q;
  assign oBusy     = busy_q;
  assign oMopAck   = ack_q;
  assign oStackErr = err_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq -- randomized scoreboard bench for dzcpu_useq.
// The stimulus side walks each flow through a reference model of the ROM/LUT
// and queues the expected (uPC, micro-op) sequence; a monitor pops one entry
// per EXEC entry and checks held values while stalled.
module tb_dzcpu_useq;

`ifdef DZCPU_USTACK_EN
  localparam int SD = 2;
`else
  localparam int SD = 4;
`endif

  logic        iClock = 1'b0, iReset = 1'b1;
  logic [7:0]  iMop = '0;
  logic        iMopValid = 1'b0, iFlagZ = 1'b0, iStall = 1'b0;
  logic        iRomWe = 1'b0, iLutWe = 1'b0;
  logic [7:0]  iRomAddr = '0, iLutData = '0;
  logic [15:0] iRomData = '0;
  logic [8:0]  iLutAddr = '0;
  logic [15:0] oUop;
  logic [7:0]  oUpc;
  logic        oUopValid, oBusy, oMopAck, oStackErr;

  dzcpu_useq #(.UOP_W(16), .UPC_W(8), .STACK_DEPTH(SD)) dut (
    .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
    .iFlagZ(iFlagZ), .iStall(iStall),
    .iRomWe(iRomWe), .iRomAddr(iRomAddr), .iRomData(iRomData),
    .iLutWe(iLutWe), .iLutAddr(iLutAddr), .iLutData(iLutData),
    .oUop(oUop), .oUopValid(oUopValid), .oUpc(oUpc), .oBusy(oBusy),
    .oMopAck(oMopAck), .oStackErr(oStackErr)
  );

  always #5 iClock = ~iClock;

  typedef struct { logic [7:0] upc; logic [15:0] uop; } exp_t;
  exp_t        sb[$];
  exp_t        last;
  logic [15:0] rom_m [256];
  logic [7:0]  lut_m [512];
  int          stk_m[$];
  int          n_tests = 0, n_fail = 0, acks_seen = 0, acks_exp = 0;
  bit          err_exp = 0, cb_pending = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] mk(input int s, input int t);
    logic [2:0] s3;
    logic [7:0] t8;
    s3 = s[2:0];
    t8 = t[7:0];
    return {s3, 5'b0, t8};
  endfunction

  task automatic tick();
    @(posedge iClock); #1;
  endtask

  task automatic rom_wr(input int a, input logic [15:0] d);
    rom_m[a] = d; iRomWe = 1'b1; iRomAddr = a[7:0]; iRomData = d;
    tick(); iRomWe = 1'b0;
  endtask

  task automatic lut_wr(input int a, input int d);
    lut_m[a] = d[7:0]; iLutWe = 1'b1; iLutAddr = a[8:0]; iLutData = d[7:0];
    tick(); iLutWe = 1'b0;
  endtask

  // Reference walk of one flow: push every micro-op that will execute.
  task automatic model_flow(input int start, input bit z, output bit cb);
    int pc;
    pc = start; cb = 0;
    for (int n = 0; n < 300; n++) begin
      exp_t e;
      logic [15:0] u;
      int s;
      u = rom_m[pc]; e.upc = pc[7:0]; e.uop = u; sb.push_back(e);
      s = int'(u[15:13]);
      case (s)
        0: pc = (pc + 1) % 256;
        1: return;
        2: if (z) return; else pc = (pc + 1) % 256;
        3: if (!z) return; else pc = (pc + 1) % 256;
        4: begin cb = 1; return; end
        5: pc = int'(u[7:0]);
        6: begin
`ifdef DZCPU_USTACK_EN
          if (stk_m.size() < SD) stk_m.push_back((pc + 1) % 256);
          else err_exp = 1;
`endif
          pc = int'(u[7:0]);
        end
        default: begin
`ifdef DZCPU_USTACK_EN
          if (stk_m.size() > 0) pc = stk_m.pop_back();
          else begin err_exp = 1; return; end
`else
          return;
`endif
        end
      endcase
    end
  endtask

  task automatic dispatch(input int mop, input bit z);
    int start;
    bit cb;
    start = int'(lut_m[(cb_pending ? 256 : 0) + mop]);
    model_flow(start, z, cb);
    cb_pending = cb;
    acks_exp++;
    iFlagZ = z; iMop = mop[7:0]; iMopValid = 1'b1;
    tick(); iMopValid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (oBusy && n < 2000) begin tick(); n++; end
    chk({nm, " busy drop"}, oBusy, 0);
    chk({nm, " drained"}, sb.size(), 0);
    chk({nm, " acks"}, acks_seen, acks_exp);
    chk({nm, " stack err"}, oStackErr, err_exp);
  endtask

  // Monitor: one expected entry per EXEC entry; stalled cycles must hold.
  initial begin : monitor
    bit pv;
    pv = 0;
    forever begin
      @(negedge iClock);
      if (iReset) begin pv = 0; continue; end
      if (oMopAck) acks_seen++;
      if (oUopValid && !pv) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected uop: got upc %0h uop %0h, expected none", oUpc, oUop);
        end else begin
          last = sb.pop_front();
          chk("uop upc", oUpc, last.upc);
          chk("uop word", oUop, last.uop);
          chk("busy in exec", oBusy, 1);
        end
      end else if (oUopValid && pv && iStall) begin
        chk("stall hold upc", oUpc, last.upc);
        chk("stall hold uop", oUop, last.uop);
      end
      pv = oUopValid;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected summary");
    $fatal(1);
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 256; i++) rom_m[i] = '0;
    for (int i = 0; i < 512; i++) lut_m[i] = '0;

    // reset values
    repeat (2) tick();
    @(negedge iClock);
    chk("rst valid", oUopValid, 0); chk("rst busy", oBusy, 0);
    chk("rst ack", oMopAck, 0);     chk("rst upc", oUpc, 0);
    chk("rst uop", oUop, 0);        chk("rst err", oStackErr, 0);
    tick(); iReset = 1'b0; tick();

    // basic flow 1,2,3 and dispatch latency
    lut_wr(16'h031, 1);
    rom_wr(1, mk(0, 0)); rom_wr(2, mk(0, 0)); rom_wr(3, mk(1, 0));
    dispatch(16'h31, 0);
    @(negedge iClock);
    chk("ack pulse", oMopAck, 1); chk("valid +1", oUopValid, 0);
    @(negedge iClock);
    chk("valid +2", oUopValid, 1);
    tick();
    wait_idle("flow31");

    // conditional end on Z
    lut_wr(16'h040, 17);
    rom_wr(17, mk(3, 0)); rom_wr(18, mk(1, 0));
    dispatch(16'h40, 1); wait_idle("eof_nz z1");
    dispatch(16'h40, 0); wait_idle("eof_nz z0");

    // CB-prefixed dispatch
    lut_wr(16'h0CB, 13); lut_wr(16'h17C, 16);
    rom_wr(13, mk(4, 0)); rom_wr(16, mk(1, 0));
    dispatch(16'hCB, 0);
    tick(); tick();
    chk("waitcb busy", oBusy, 1); chk("waitcb valid", oUopValid, 0);
    dispatch(16'h7C, 0); wait_idle("jcb");

    // stall holds for 5 cycles; a byte offered meanwhile is ignored
    lut_wr(16'h050, 30);
    rom_wr(30, mk(0, 0)); rom_wr(31, mk(0, 0)); rom_wr(32, mk(1, 0));
    dispatch(16'h50, 0);
    n = 0;
    while (!oUopValid && n < 50) begin tick(); n++; end
    iStall = 1'b1; iMop = 8'h31; iMopValid = 1'b1;
    repeat (5) tick();
    iStall = 1'b0; iMopValid = 1'b0;
    wait_idle("stall");

    // uPC wrap and unprogrammed opcode (flow 0)
    rom_wr(255, mk(0, 0)); rom_wr(0, mk(1, 0)); lut_wr(16'h0FF, 255);
    dispatch(16'hFF, 0); wait_idle("wrap");
    dispatch(16'h99, 0); wait_idle("unprog");

    // reset mid-flow at uPC 40, then rerun from preserved ROM
    lut_wr(16'h060, 38);
    rom_wr(38, mk(0, 0)); rom_wr(39, mk(0, 0)); rom_wr(40, mk(0, 0)); rom_wr(41, mk(1, 0));
    dispatch(16'h60, 0);
    n = 0;
    while (!(oUopValid && oUpc == 8'd40) && n < 50) begin tick(); n++; end
    chk("reached upc40", oUpc, 40);
    iReset = 1'b1;
    @(negedge iClock);
    chk("midrst valid", oUopValid, 0); chk("midrst busy", oBusy, 0);
    chk("midrst upc", oUpc, 0);
    sb.delete(); stk_m.delete(); err_exp = 0; cb_pending = 0;
    tick(); iReset = 1'b0; tick();
    dispatch(16'h31, 0); wait_idle("after reset");

`ifdef DZCPU_USTACK_EN
    // three nested calls into a 2-deep stack
    lut_wr(16'h0D0, 200);
    rom_wr(200, mk(6, 210)); rom_wr(201, mk(1, 0));
    rom_wr(210, mk(6, 220)); rom_wr(211, mk(7, 0));
    rom_wr(220, mk(6, 230)); rom_wr(221, mk(7, 0));
    rom_wr(230, mk(7, 0));
    dispatch(16'hD0, 0); wait_idle("nested call");
`endif

    // random forward-only flows in ROM 64..127
    for (int r = 0; r < 3; r++) begin
      for (int a = 64; a < 128; a++) begin
        int s, t;
        logic [4:0] m;
        if (a == 127) s = 1;
        else begin
`ifdef DZCPU_USTACK_EN
          s = $urandom_range(0, 4); if (s == 4) s = 5;
`else
          s = $urandom_range(0, 6); if (s >= 4) s = s + 1;
`endif
        end
        t = (s == 5 || s == 6) ? $urandom_range(127, a + 1) : $urandom_range(0, 255);
        m = 5'($urandom);
        rom_wr(a, mk(s, t) | {3'b0, m, 8'b0});
      end
      for (int k = 0; k < 8; k++) lut_wr(16'h0A0 + k, $urandom_range(64, 127));
      for (int f = 0; f < 10; f++) begin
        dispatch(16'hA0 + $urandom_range(0, 7), 1'($urandom));
        wait_idle("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
